// File: rtl/lit_scan_mux.sv
// lit_scan_mux: registered N:1 literal selector with direct and scan modes.
// Scan walks a masked snapshot in ascending index order over valid/ready.
module lit_scan_mux #(
    parameter int N_IN  = 8,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN*W-1:0] in_data,
    input  logic [N_IN-1:0]   in_mask,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic              start,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_idx,
    output logic              busy,
    output logic              done,
    output logic              sel_err
);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN, DONE} state_t;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_IN - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     snap_q [N_IN];
    logic [N_IN-1:0]  mask_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] ptr_q;
    logic             sel_err_q;
    logic             accept;
    logic             step;
    logic             cur_en;
    logic             sel_q_bad;

    assign accept    = (state_q == IDLE) && start && !flush;
    assign cur_en    = mask_q[ptr_q];
    assign sel_q_bad = int'(sel_q) >= N_IN;
    // A scan slot is left when it is accepted or when it is masked off.
    assign step      = (state_q == SCAN) && (!cur_en || out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = mode ? SCAN : DIRECT;
                DIRECT:  if (out_ready) state_d = DONE;
                SCAN:    if (step && ptr_q == LAST) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) snap_q[i] <= '0;
            mask_q    <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            sel_err_q <= 1'b0;
        end else if (flush) begin
            ptr_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_IN; i++) snap_q[i] <= in_data[i*W +: W];
            mask_q    <= in_mask;
            sel_q     <= sel;
            ptr_q     <= '0;
            sel_err_q <= !mode && (int'(sel) >= N_IN);
        end else if (step && ptr_q != LAST) begin
            ptr_q <= ptr_q + SEL_W'(1);
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        busy      = state_q != IDLE;
        done      = state_q == DONE;
        unique case (state_q)
            DIRECT: begin
                out_valid = 1'b1;
                if (!sel_q_bad) begin
                    out_data = snap_q[sel_q];
                    out_idx  = sel_q;
                end
            end
            SCAN: begin
                out_valid = cur_en;
                out_data  = snap_q[ptr_q];
                out_idx   = ptr_q;
            end
            default: ;
        endcase
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_lit_scan_mux.sv
// Bench for lit_scan_mux: queue-based reference model checked every cycle,
// plus directed timing checks and an N_IN=10 instance for the select error.
module tb_lit_scan_mux;

    localparam int N = 8;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, mode, start, flush, out_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_mask;
    logic [2:0]     sel;
    logic           out_valid, busy, done, sel_err;
    logic [W-1:0]   out_data;
    logic [2:0]     out_idx;

    logic        b_mode, b_start, b_flush, b_ready;
    logic [39:0] b_data;
    logic [9:0]  b_mask;
    logic [3:0]  b_sel;
    logic        b_valid, b_busy, b_done, b_err;
    logic [3:0]  b_out_data, b_out_idx;

    lit_scan_mux #(.N_IN(N), .W(W)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_mask(in_mask),
        .mode(mode), .sel(sel), .start(start), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .busy(busy), .done(done), .sel_err(sel_err)
    );

    lit_scan_mux #(.N_IN(10), .W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_mask(b_mask),
        .mode(b_mode), .sel(b_sel), .start(b_start), .flush(b_flush),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .busy(b_busy), .done(b_done), .sel_err(b_err)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct { int c; int idx; int data; } beat_t;
    beat_t beats[$];
    int    dones[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    // Reference model: an operation is a queue of pending slots.
    int           m_phase = 0;
    logic [W-1:0] m_snap [N];
    logic [N-1:0] m_mask;
    int           m_sel;
    int           m_q[$];

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_phase = 0;
            m_q     = {};
            m_mask  = '0;
            m_sel   = 0;
            for (int i = 0; i < N; i++) m_snap[i] = '0;
        end else if (flush) begin
            m_phase = 0;
            m_q     = {};
        end else begin
            case (m_phase)
                0: if (start) begin
                    for (int i = 0; i < N; i++) m_snap[i] = in_data[i*W +: W];
                    m_mask = in_mask;
                    m_sel  = int'(sel);
                    if (mode) begin
                        m_q = {};
                        for (int i = 0; i < N; i++) m_q.push_back(i);
                        m_phase = 2;
                    end else begin
                        m_phase = 1;
                    end
                end
                1: if (out_ready) m_phase = 3;
                2: begin
                    if (out_ready || !m_mask[m_q[0]]) void'(m_q.pop_front());
                    if (m_q.size() == 0) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin : cmp
        int ev, ed, ei;
        ev = 0; ed = 0; ei = 0;
        if (m_phase == 1) begin
            ev = 1; ed = int'(m_snap[m_sel]); ei = m_sel;
        end else if (m_phase == 2) begin
            ei = m_q[0]; ev = int'(m_mask[ei]); ed = int'(m_snap[ei]);
        end
        chk("out_valid", int'(out_valid), ev);
        chk("out_data", int'(out_data), ed);
        chk("out_idx", int'(out_idx), ei);
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("done", int'(done), int'(m_phase == 3));
        chk("sel_err", int'(sel_err), 0);
        if (out_valid && out_ready)
            beats.push_back('{cyc, int'(out_idx), int'(out_data)});
        if (done) dones.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        beats = {};
        dones = {};
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (dones.size() == 0 && k < limit) begin
            tick();
            k++;
        end
        if (dones.size() == 0) chk("done_timeout", 1, 0);
    endtask

    function automatic int first_done();
        return (dones.size() != 0) ? dones[0] : -1;
    endfunction

    int t;

    initial begin
        rst_n = 0; start = 0; flush = 0; mode = 0; sel = '0;
        out_ready = 0; in_data = '0; in_mask = '0;
        b_mode = 0; b_start = 0; b_flush = 0; b_ready = 0;
        b_data = '0; b_mask = '0; b_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (5) tick();
        chk("idle_after_reset", int'({out_valid, busy, done, out_data}), 0);

        // Direct select with stall; in_data changes after the start.
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 4'(i + 3);
        clear_logs();
        sel = 3'd5; mode = 0; out_ready = 0; start = 1; t = cyc;
        tick();
        start = 0; in_data = '1;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) out_ready = 1;
            @(negedge clk);
            chk("dir_hold_valid", int'(out_valid), 1);
            chk("dir_hold_data", int'(out_data), 8);
            chk("dir_hold_idx", int'(out_idx), 5);
            tick();
        end
        out_ready = 0;
        wait_done(5);
        chk("dir_done_cycle", first_done(), t + 4);
        chk("dir_beat_count", beats.size(), 1);
        repeat (2) tick();

        // Back-to-back direct operations, one per 3 cycles.
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 4'(i + 3);
        clear_logs();
        sel = 3'd0; out_ready = 1; start = 1; t = cyc;
        tick();
        start = 0;
        wait_done(6);
        chk("dir_fast_done", first_done(), t + 2);
        clear_logs();
        sel = 3'd2; start = 1; t = cyc;
        tick();
        start = 0;
        wait_done(6);
        chk("dir_b2b_done", first_done(), t + 2);
        chk("dir_b2b_data", (beats.size() != 0) ? beats[0].data : -1, 5);
        repeat (2) tick();

        // Sparse scan, ready held high.
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 4'(2 * i + 1);
        clear_logs();
        in_mask = 8'b1010_0101; mode = 1; out_ready = 1; start = 1; t = cyc;
        tick();
        start = 0;
        wait_done(15);
        chk("sparse_count", beats.size(), 4);
        if (beats.size() == 4) begin
            int ix[4], cy[4];
            ix = '{0, 2, 5, 7};
            cy = '{1, 3, 6, 8};
            for (int k = 0; k < 4; k++) begin
                chk("sparse_idx", beats[k].idx, ix[k]);
                chk("sparse_cycle", beats[k].c, t + cy[k]);
                chk("sparse_data", beats[k].data, 2 * ix[k] + 1);
            end
        end
        chk("sparse_done", first_done(), t + 9);
        repeat (2) tick();

        // Full scan with alternating back-pressure.
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 4'(15 - i);
        clear_logs();
        in_mask = 8'hFF; out_ready = 0; start = 1; t = cyc;
        tick();
        start = 0;
        for (int k = 0; k < 40 && dones.size() == 0; k++) begin
            out_ready = ((cyc - t) % 2) == 1;
            tick();
        end
        out_ready = 1;
        chk("bp_count", beats.size(), 8);
        if (beats.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("bp_idx", beats[k].idx, k);
                chk("bp_data", beats[k].data, 15 - k);
                chk("bp_cycle", beats[k].c, t + 1 + 2 * k);
            end
        end
        chk("bp_done", first_done(), t + 16);
        repeat (2) tick();

        // Empty mask.
        clear_logs();
        in_mask = '0; start = 1; t = cyc;
        tick();
        start = 0;
        wait_done(15);
        chk("empty_beats", beats.size(), 0);
        chk("empty_done", first_done(), t + 9);
        repeat (2) tick();

        // Start while scanning is ignored; flush with start at ptr=3.
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 4'(i + 8);
        clear_logs();
        in_mask = 8'hFF; mode = 1; out_ready = 1; start = 1; t = cyc;
        tick();
        start = 0;
        tick();
        start = 1; mode = 0; sel = 3'd1; in_data = '0; in_mask = '0;
        tick();
        start = 0;
        tick();
        flush = 1; start = 1;
        @(negedge clk);
        chk("flush_ptr", int'(out_idx), 3);
        tick();
        flush = 0; start = 0;
        @(negedge clk);
        chk("flush_valid", int'(out_valid), 0);
        chk("flush_busy", int'(busy), 0);
        repeat (3) tick();
        chk("flush_no_done", dones.size(), 0);
        chk("flush_beats", beats.size(), 4);
        chk("busy_start_snap", (beats.size() > 2) ? beats[2].data : -1, 10);

        // Flush together with start while idle.
        flush = 1; start = 1; mode = 0;
        tick();
        flush = 0; start = 0;
        @(negedge clk);
        chk("idle_flush_start", int'(busy), 0);
        tick();

        // Select error on the N_IN=10 instance.
        for (int i = 0; i < 10; i++) b_data[i*4 +: 4] = 4'(i + 1);
        b_sel = 4'd9; b_mode = 0; b_ready = 1; b_start = 1;
        tick();
        b_start = 0;
        @(negedge clk);
        chk("b9_valid", int'(b_valid), 1);
        chk("b9_data", int'(b_out_data), 10);
        chk("b9_idx", int'(b_out_idx), 9);
        chk("b9_err", int'(b_err), 0);
        repeat (3) tick();
        b_sel = 4'd12; b_start = 1;
        tick();
        b_start = 0;
        @(negedge clk);
        chk("b12_valid", int'(b_valid), 1);
        chk("b12_data", int'(b_out_data), 0);
        chk("b12_idx", int'(b_out_idx), 0);
        chk("b12_err", int'(b_err), 1);
        repeat (3) tick();
        @(negedge clk);
        chk("b12_err_latched", int'(b_err), 1);
        chk("b12_idle", int'(b_busy), 0);
        tick();
        b_ready = 0; b_start = 1;
        tick();
        b_start = 0; b_flush = 1;
        tick();
        b_flush = 0;
        @(negedge clk);
        chk("b_flush_idle", int'(b_busy), 0);
        chk("b_flush_err_kept", int'(b_err), 1);
        tick();
        b_mode = 1; b_mask = '0; b_start = 1;
        tick();
        b_start = 0;
        @(negedge clk);
        chk("b_err_cleared", int'(b_err), 0);
        chk("b_scan_busy", int'(b_busy), 1);
        repeat (12) tick();
        chk("b_scan_finished", int'(b_busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
